// File: rtl/sm4_encryptor_pkg.sv
// Shared definitions for the SM4 key cache:
// - the cipher group size,
// - the lookup FSM state type,
// - a small index helper.
package sm4_encryptor_pkg;

    localparam int group_size_p = 128;

    typedef enum logic [0:0] {
        eReady = 1'b0,
        eResp  = 1'b1
    } sm4_kc_state_e;

    // Returns the index of the lowest set bit of vec (0 when vec is empty).
    function automatic logic [3:0] lowest_set_idx(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sm4_kc_lru.sv
// Age-based LRU tracker for the SM4 key cache.
// Each way holds an age. Ages always form a permutation of 0..els_p-1.
// The way whose age is els_p-1 is the least recently used.
module sm4_kc_lru #(
    parameter int els_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     touch_v,
    input  logic [$clog2(els_p)-1:0] touch_way,
    output logic [$clog2(els_p)-1:0] lru_way
);

    localparam int way_w_lp = $clog2(els_p);

    logic [way_w_lp-1:0] age_r [els_p];
    logic [way_w_lp-1:0] touch_age_s;

    assign touch_age_s = age_r[touch_way];

    // Touched way becomes youngest; ways younger than it age by one.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                age_r[i] <= way_w_lp'(i);
            end
        end else if (touch_v) begin
            for (int i = 0; i < els_p; i++) begin
                if (way_w_lp'(i) == touch_way) begin
                    age_r[i] <= '0;
                end else if (age_r[i] < touch_age_s) begin
                    age_r[i] <= age_r[i] + way_w_lp'(1);
                end
            end
        end
    end

    // Locate the way carrying the oldest age.
    always_comb begin
        lru_way = '0;
        for (int i = 0; i < els_p; i++) begin
            if (age_r[i] == way_w_lp'(els_p - 1)) begin
                lru_way = way_w_lp'(i);
            end else begin
                lru_way = lru_way;
            end
        end
    end

endmodule

// File: rtl/sm4_key_cache.sv
// Fully associative cache of SM4 round-key bundles, tagged by cipher key.
// A lookup is accepted in eReady. Its result is held in eResp until consumed.
// Fills and invalidates act at the clock edge, independently of lookups.
module sm4_key_cache
    import sm4_encryptor_pkg::*;
#(
    parameter int els_p        = 4,
    parameter int tag_width_p  = group_size_p,
    parameter int data_width_p = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [tag_width_p-1:0]   key_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic                     hit_o,
    output logic [$clog2(els_p)-1:0] way_o,
    output logic [data_width_p-1:0]  data_o,
    input  logic                     yumi_i,
    input  logic                     fill_v_i,
    input  logic [$clog2(els_p)-1:0] fill_way_i,
    input  logic [tag_width_p-1:0]   fill_key_i,
    input  logic [data_width_p-1:0]  fill_data_i,
    input  logic                     inval_all_i,
    input  logic                     inval_v_i,
    input  logic [tag_width_p-1:0]   inval_key_i,
    output logic [15:0]              hit_cnt_o,
    output logic [15:0]              miss_cnt_o
);

    localparam int way_w_lp = $clog2(els_p);

    sm4_kc_state_e           state_r;
    logic [els_p-1:0]        valid_r;
    logic [tag_width_p-1:0]  tag_r  [els_p];
    logic [data_width_p-1:0] data_r [els_p];

    logic                    v_r;
    logic                    hit_r;
    logic [way_w_lp-1:0]     way_r;
    logic [data_width_p-1:0] data_out_r;
    logic [15:0]             hit_cnt_r;
    logic [15:0]             miss_cnt_r;

    logic [els_p-1:0]        hit_vec_s;
    logic [els_p-1:0]        fill_dup_vec_s;
    logic [els_p-1:0]        inval_vec_s;
    logic [els_p-1:0]        valid_nxt_s;
    logic [way_w_lp-1:0]     hit_way_s;
    logic [way_w_lp-1:0]     victim_way_s;
    logic [way_w_lp-1:0]     lru_way_s;
    logic [way_w_lp-1:0]     touch_way_s;
    logic [3:0]              first_invalid_s;
    logic                    hit_any_s;
    logic                    accept_s;
    logic                    fill_eff_s;
    logic                    inval_en_s;
    logic                    touch_v_s;

    assign accept_s        = v_i & (state_r == eReady);
    assign hit_any_s       = |hit_vec_s;
    assign fill_eff_s      = fill_v_i & ~inval_all_i;
    assign inval_en_s      = inval_v_i & ~(fill_v_i & (inval_key_i == fill_key_i));
    assign first_invalid_s = lowest_set_idx(16'(~valid_r));
    assign victim_way_s    = (&valid_r) ? lru_way_s : first_invalid_s[way_w_lp-1:0];
    assign touch_v_s       = fill_eff_s | (accept_s & hit_any_s);
    assign touch_way_s     = fill_eff_s ? fill_way_i : hit_way_s;

    // Tag matches against the current (pre-edge) array contents.
    always_comb begin
        hit_vec_s      = '0;
        fill_dup_vec_s = '0;
        inval_vec_s    = '0;
        hit_way_s      = '0;
        for (int i = 0; i < els_p; i++) begin
            hit_vec_s[i]      = valid_r[i] && (tag_r[i] == key_i);
            fill_dup_vec_s[i] = valid_r[i] && (tag_r[i] == fill_key_i)
                                && (way_w_lp'(i) != fill_way_i);
            inval_vec_s[i]    = valid_r[i] && (tag_r[i] == inval_key_i);
            if (hit_vec_s[i]) begin
                hit_way_s = way_w_lp'(i);
            end else begin
                hit_way_s = hit_way_s;
            end
        end
    end

    // Next valid bits: inval_all beats fill, fill beats a single invalidate.
    always_comb begin
        valid_nxt_s = valid_r;
        if (inval_all_i) begin
            valid_nxt_s = '0;
        end else begin
            if (inval_en_s) begin
                valid_nxt_s = valid_nxt_s & ~inval_vec_s;
            end else begin
                valid_nxt_s = valid_nxt_s;
            end
            if (fill_v_i) begin
                valid_nxt_s = valid_nxt_s & ~fill_dup_vec_s;
                valid_nxt_s[fill_way_i] = 1'b1;
            end else begin
                valid_nxt_s = valid_nxt_s;
            end
        end
    end

    // Valid bit storage.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_r <= '0;
        end else begin
            valid_r <= valid_nxt_s;
        end
    end

    // Tag and round-key storage; contents are qualified by valid_r.
    always_ff @(posedge clk_i) begin
        if (fill_eff_s) begin
            tag_r[fill_way_i]  <= fill_key_i;
            data_r[fill_way_i] <= fill_data_i;
        end
    end

    // Lookup FSM: accept in eReady, hold the result in eResp until consumed.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= eReady;
            v_r     <= 1'b0;
        end else begin
            case (state_r)
                eReady: begin
                    if (accept_s) begin
                        state_r <= eResp;
                        v_r     <= 1'b1;
                    end
                end
                eResp: begin
                    if (yumi_i) begin
                        state_r <= eReady;
                        v_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r <= eReady;
                    v_r     <= 1'b0;
                end
            endcase
        end
    end

    // Capture the lookup result and bump the hit/miss counters on acceptance.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hit_r      <= 1'b0;
            way_r      <= '0;
            data_out_r <= '0;
            hit_cnt_r  <= 16'd0;
            miss_cnt_r <= 16'd0;
        end else if (accept_s) begin
            hit_r <= hit_any_s;
            if (hit_any_s) begin
                way_r      <= hit_way_s;
                data_out_r <= data_r[hit_way_s];
                hit_cnt_r  <= hit_cnt_r + 16'd1;
            end else begin
                way_r      <= victim_way_s;
                data_out_r <= '0;
                miss_cnt_r <= miss_cnt_r + 16'd1;
            end
        end
    end

    sm4_kc_lru #(
        .els_p(els_p)
    ) u_lru (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .touch_v  (touch_v_s),
        .touch_way(touch_way_s),
        .lru_way  (lru_way_s)
    );

    assign ready_o    = (state_r == eReady);
    assign v_o        = v_r;
    assign hit_o      = hit_r;
    assign way_o      = way_r;
    assign data_o     = data_out_r;
    assign hit_cnt_o  = hit_cnt_r;
    assign miss_cnt_o = miss_cnt_r;

endmodule

// File: tb/tb_sm4_key_cache.sv
// Directed bench for sm4_key_cache with its default parameters (4 ways).
module tb_sm4_key_cache;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          v_i;
    logic [127:0]  key_i;
    logic          ready_o;
    logic          v_o;
    logic          hit_o;
    logic [1:0]    way_o;
    logic [1023:0] data_o;
    logic          yumi_i;
    logic          fill_v_i;
    logic [1:0]    fill_way_i;
    logic [127:0]  fill_key_i;
    logic [1023:0] fill_data_i;
    logic          inval_all_i;
    logic          inval_v_i;
    logic [127:0]  inval_key_i;
    logic [15:0]   hit_cnt_o;
    logic [15:0]   miss_cnt_o;

    int            n_vec = 0;
    int            n_err = 0;
    logic [15:0]   exp_hits = 16'd0;
    logic [15:0]   exp_misses = 16'd0;

    logic [127:0]  k_cold, k_a, k0, k1, k2, k3, k_new, k5, k7, k8, k_other;
    logic [1023:0] d_a, d0, d1, d2, d3, d_x, d5, d7, d8;

    sm4_key_cache dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .v_i        (v_i),
        .key_i      (key_i),
        .ready_o    (ready_o),
        .v_o        (v_o),
        .hit_o      (hit_o),
        .way_o      (way_o),
        .data_o     (data_o),
        .yumi_i     (yumi_i),
        .fill_v_i   (fill_v_i),
        .fill_way_i (fill_way_i),
        .fill_key_i (fill_key_i),
        .fill_data_i(fill_data_i),
        .inval_all_i(inval_all_i),
        .inval_v_i  (inval_v_i),
        .inval_key_i(inval_key_i),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic exp_hit, input logic [1:0] exp_way,
                                input logic [1023:0] exp_data);
        if (exp_hit) exp_hits = exp_hits + 16'd1;
        else         exp_misses = exp_misses + 16'd1;
        check({tag, ".v_o"},      {1023'd0, v_o},       {1023'd0, 1'b1});
        check({tag, ".ready_o"},  {1023'd0, ready_o},   {1023'd0, 1'b0});
        check({tag, ".hit_o"},    {1023'd0, hit_o},     {1023'd0, exp_hit});
        check({tag, ".way_o"},    {1022'd0, way_o},     {1022'd0, exp_way});
        check({tag, ".data_o"},   data_o,               exp_data);
        check({tag, ".hit_cnt"},  {1008'd0, hit_cnt_o}, {1008'd0, exp_hits});
        check({tag, ".miss_cnt"}, {1008'd0, miss_cnt_o}, {1008'd0, exp_misses});
    endtask

    task automatic lookup(input string tag, input logic [127:0] key, input logic exp_hit,
                          input logic [1:0] exp_way, input logic [1023:0] exp_data);
        @(negedge clk);
        v_i   = 1'b1;
        key_i = key;
        @(posedge clk);
        #1;
        v_i = 1'b0;
        check_result(tag, exp_hit, exp_way, exp_data);
    endtask

    task automatic pop(input string tag);
        @(negedge clk);
        yumi_i = 1'b1;
        @(posedge clk);
        #1;
        yumi_i = 1'b0;
        check({tag, ".pop_v_o"},   {1023'd0, v_o},     {1023'd0, 1'b0});
        check({tag, ".pop_ready"}, {1023'd0, ready_o}, {1023'd0, 1'b1});
    endtask

    task automatic fill(input logic [1:0] way, input logic [127:0] key, input logic [1023:0] data);
        @(negedge clk);
        fill_v_i    = 1'b1;
        fill_way_i  = way;
        fill_key_i  = key;
        fill_data_i = data;
        @(posedge clk);
        #1;
        fill_v_i = 1'b0;
    endtask

    task automatic inval(input logic [127:0] key);
        @(negedge clk);
        inval_v_i   = 1'b1;
        inval_key_i = key;
        @(posedge clk);
        #1;
        inval_v_i = 1'b0;
    endtask

    initial begin
        k_cold  = 128'h0123456789ABCDEF0123456789ABCDEF;
        k_a     = 128'hA5A5A5A5_00000000_11111111_5A5A5A5A;
        k0      = 128'h00000000_00000000_00000000_0000C0DE;
        k1      = 128'h11111111_11111111_11111111_1111C0DE;
        k2      = 128'h22222222_22222222_22222222_2222C0DE;
        k3      = 128'h33333333_33333333_33333333_3333C0DE;
        k_new   = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        k5      = 128'h55555555_55555555_55555555_55555555;
        k7      = 128'h77777777_77777777_77777777_77777777;
        k8      = 128'h88888888_88888888_88888888_88888888;
        k_other = 128'hFEEDFACE_FEEDFACE_FEEDFACE_FEEDFACE;
        d_a = {32{32'hDA7A0A0A}};
        d0  = {32{32'hD0D0D0D0}};
        d1  = {32{32'hD1D1D1D1}};
        d2  = {32{32'hD2D2D2D2}};
        d3  = {32{32'hD3D3D3D3}};
        d_x = {32{32'hCAFEF00D}};
        d5  = {32{32'h5D5D5D5D}};
        d7  = {32{32'h7D7D7D7D}};
        d8  = {32{32'h8D8D8D8D}};

        reset_i     = 1'b1;
        v_i         = 1'b0;
        key_i       = 128'd0;
        yumi_i      = 1'b0;
        fill_v_i    = 1'b0;
        fill_way_i  = 2'd0;
        fill_key_i  = 128'd0;
        fill_data_i = 1024'd0;
        inval_all_i = 1'b0;
        inval_v_i   = 1'b0;
        inval_key_i = 128'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready",    {1023'd0, ready_o},    {1023'd0, 1'b1});
        check("rst.v_o",      {1023'd0, v_o},        {1023'd0, 1'b0});
        check("rst.hit_o",    {1023'd0, hit_o},      {1023'd0, 1'b0});
        check("rst.way_o",    {1022'd0, way_o},      {1022'd0, 2'd0});
        check("rst.data_o",   data_o,                1024'd0);
        check("rst.hit_cnt",  {1008'd0, hit_cnt_o},  {1008'd0, 16'd0});
        check("rst.miss_cnt", {1008'd0, miss_cnt_o}, {1008'd0, 16'd0});
        @(negedge clk);
        reset_i = 1'b0;

        // Cold lookup misses into way 0.
        lookup("cold", k_cold, 1'b0, 2'd0, 1024'd0);
        pop("cold");

        // Fill then hit.
        fill(2'd0, k_a, d_a);
        lookup("fill_hit", k_a, 1'b1, 2'd0, d_a);
        pop("fill_hit");

        // LRU eviction: ages become [3,2,1,0], then the hit on K0 makes way 1 oldest.
        fill(2'd0, k0, d0);
        fill(2'd1, k1, d1);
        fill(2'd2, k2, d2);
        fill(2'd3, k3, d3);
        lookup("lru_hit_k0", k0, 1'b1, 2'd0, d0);
        pop("lru_hit_k0");
        lookup("lru_victim", k_new, 1'b0, 2'd1, 1024'd0);
        pop("lru_victim");

        // A duplicate fill moves K0 to way 2 and frees way 0.
        fill(2'd2, k0, d_x);
        lookup("dup_hit", k0, 1'b1, 2'd2, d_x);
        pop("dup_hit");
        lookup("dup_freed", k_new, 1'b0, 2'd0, 1024'd0);
        pop("dup_freed");
        lookup("dup_overwr", k2, 1'b0, 2'd0, 1024'd0);
        pop("dup_overwr");
        inval(k0);
        lookup("inval_miss", k0, 1'b0, 2'd0, 1024'd0);
        pop("inval_miss");
        inval(k_other);

        // A fill in the same cycle as a lookup is not visible to that lookup.
        @(negedge clk);
        v_i         = 1'b1;
        key_i       = k5;
        fill_v_i    = 1'b1;
        fill_way_i  = 2'd0;
        fill_key_i  = k5;
        fill_data_i = d5;
        @(posedge clk);
        #1;
        v_i      = 1'b0;
        fill_v_i = 1'b0;
        check_result("same_cyc", 1'b0, 2'd0, 1024'd0);
        pop("same_cyc");
        lookup("same_cyc_after", k5, 1'b1, 2'd0, d5);
        pop("same_cyc_after");

        // inval_all wins over a simultaneous fill.
        @(negedge clk);
        inval_all_i = 1'b1;
        fill_v_i    = 1'b1;
        fill_way_i  = 2'd1;
        fill_key_i  = k7;
        fill_data_i = d7;
        @(posedge clk);
        #1;
        inval_all_i = 1'b0;
        fill_v_i    = 1'b0;
        lookup("inv_all_k7", k7, 1'b0, 2'd0, 1024'd0);
        pop("inv_all_k7");
        lookup("inv_all_k1", k1, 1'b0, 2'd0, 1024'd0);
        pop("inv_all_k1");

        // Invalidate of the key being filled in the same cycle is ignored.
        @(negedge clk);
        fill_v_i    = 1'b1;
        fill_way_i  = 2'd1;
        fill_key_i  = k8;
        fill_data_i = d8;
        inval_v_i   = 1'b1;
        inval_key_i = k8;
        @(posedge clk);
        #1;
        fill_v_i  = 1'b0;
        inval_v_i = 1'b0;
        lookup("fill_inval", k8, 1'b1, 2'd1, d8);
        pop("fill_inval");

        // yumi_i is ignored in eReady.
        @(negedge clk);
        yumi_i = 1'b1;
        @(posedge clk);
        #1;
        yumi_i = 1'b0;
        check("idle_yumi.v_o",   {1023'd0, v_o},     {1023'd0, 1'b0});
        check("idle_yumi.ready", {1023'd0, ready_o}, {1023'd0, 1'b1});

        // Back-pressure: the result stays put and new requests are refused.
        lookup("bp", k8, 1'b1, 2'd1, d8);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            v_i   = 1'b1;
            key_i = k_other;
            @(posedge clk);
            #1;
            check("bp.v_o",     {1023'd0, v_o},        {1023'd0, 1'b1});
            check("bp.ready",   {1023'd0, ready_o},    {1023'd0, 1'b0});
            check("bp.hit_o",   {1023'd0, hit_o},      {1023'd0, 1'b1});
            check("bp.way_o",   {1022'd0, way_o},      {1022'd0, 2'd1});
            check("bp.data_o",  data_o,                d8);
            check("bp.miss_cnt", {1008'd0, miss_cnt_o}, {1008'd0, exp_misses});
        end
        v_i = 1'b0;
        pop("bp");

        // Reset while a result is pending.
        lookup("mid_rst", k8, 1'b1, 2'd1, d8);
        #2;
        reset_i = 1'b1;
        #1;
        check("mid_rst.v_o",    {1023'd0, v_o},     {1023'd0, 1'b0});
        check("mid_rst.ready",  {1023'd0, ready_o}, {1023'd0, 1'b1});
        check("mid_rst.data_o", data_o,             1024'd0);
        @(negedge clk);
        reset_i = 1'b0;
        exp_hits   = 16'd0;
        exp_misses = 16'd0;
        @(posedge clk);
        #1;
        check("post_rst.v_o",   {1023'd0, v_o},       {1023'd0, 1'b0});
        check("post_rst.hcnt",  {1008'd0, hit_cnt_o}, {1008'd0, 16'd0});
        lookup("post_rst_k8", k8, 1'b0, 2'd0, 1024'd0);
        pop("post_rst_k8");
        lookup("post_rst_k5", k5, 1'b0, 2'd0, 1024'd0);
        pop("post_rst_k5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sm4_key_cache.md
SM4_KEY_CACHE -- requirements
Module: sm4_key_cache

Interface
REQ-001 SHALL have parameter els_p, default 4, meaning number of cache ways (power of 2, 2..16).
REQ-002 SHALL have parameter tag_width_p, default group_size_p (128), meaning width of the cipher key used as tag.
REQ-003 SHALL have parameter data_width_p, default 1024, meaning width of cached round-key bundle (32 x 32-bit rk).
REQ-004 SHALL have ports, one per line as `name  direction  width  meaning`:
- clk_i  in  1  sole clock.
- reset_i  in  1  reset, asynchronous, active-high.
- v_i  in  1  lookup request valid.
- key_i  in  tag_width_p  lookup key.
- ready_o  out  1  lookup accepted when v_i & ready_o.
- v_o  out  1  lookup result valid.
- hit_o  out  1  result is hit.
- way_o  out  clog2(els_p)  hit way, or victim way on miss.
- data_o  out  data_width_p  round keys of hit way; 0 on miss.
- yumi_i  in  1  result consumed; legal only when v_o=1.
- fill_v_i  in  1  write entry.
- fill_way_i  in  clog2(els_p)  way to write.
- fill_key_i  in  tag_width_p  tag to write.
- fill_data_i  in  data_width_p  round keys to write.
- inval_all_i  in  1  clear all valid bits.
- inval_v_i  in  1  invalidate the entry matching inval_key_i.
- inval_key_i  in  tag_width_p  key to invalidate.
- hit_cnt_o  out  16  wrapping count of hits.
- miss_cnt_o  out  16  wrapping count of misses.

Function
REQ-005 SHALL run FSM with states eReady and eResp; ready_o=1 only in eReady.
REQ-006 SHALL move eReady->eResp on v_i&ready_o, and eResp->eReady on yumi_i; otherwise SHALL hold state.
REQ-007 SHALL assert v_o exactly one cycle after acceptance and hold hit_o/way_o/data_o stable while in eResp.
REQ-008 SHALL compute the result against array contents as they were before any same-cycle fill or invalidate.
REQ-009 SHALL report a miss way_o as the lowest-index invalid way; with all ways valid, SHALL report the LRU way.
REQ-010 SHALL track LRU with per-way ages of clog2(els_p) bits. On hit or fill, the touched way SHALL get age 0 and ways younger than it SHALL increment. Ages SHALL remain a permutation of 0..els_p-1.
REQ-011 SHALL apply fill at the clock edge. A fill whose key matches another valid way SHALL invalidate that other way, so no duplicate tags exist.
REQ-012 SHALL give priority inval_all_i > fill_v_i > inval_v_i. An inval_v_i for the same key as a same-cycle fill SHALL be ignored.
REQ-013 SHALL make inval_v_i on an absent key a no-op; invalidation SHALL NOT change ages.
REQ-014 SHALL increment hit_cnt_o/miss_cnt_o once per accepted lookup, wrapping 0xFFFF->0.
REQ-015 SHALL ignore yumi_i in eReady.

Reset
REQ-016 SHALL, on asynchronous reset_i assertion, set:
- all valid bits to 0.
- age[i] to i.
- state to eReady, ready_o=1, v_o=0, hit_o=0, way_o=0, data_o=0.
- counters to 0.
REQ-017 SHALL abandon any pending result on mid-operation reset, with no stale v_o after release.

Structure
REQ-018 SHALL place group_size_p and the enum sm4_kc_state_e {eReady, eResp} in sm4_encryptor_pkg.
REQ-019 SHALL implement the age tracker as sub-module sm4_kc_lru (parameter els_p; inputs touch_v, touch_way; output lru_way).

Verification
REQ-020 Cold lookup: after reset, lookup key 0x0123...CDEF -> v_o next cycle, hit_o=0, way_o=0, miss_cnt_o=1.
REQ-021 Fill then hit: fill way 0 with key K and data D, then lookup K -> hit_o=1, way_o=0, data_o=D, hit_cnt_o=1.
REQ-022 LRU eviction: els_p=4, fill ways 0-3 with K0..K3, hit K0, then lookup new key -> miss, way_o=1.
REQ-023 Duplicate and invalidate:
- Fill K into way 2 while K is held in way 0 -> lookup K gives way_o=2 and way 0 is invalid.
- inval_v_i K -> next lookup K misses.
REQ-024 Back-pressure and reset:
- Hold yumi_i=0 for 5 cycles -> outputs stable and ready_o=0.
- Assert reset_i mid-eResp -> v_o=0 immediately, and all lookups afterwards miss.
